// File: rtl/alu_i_if.sv
// Operand/result bundle between the integer issue logic and alu_i.
// master: issue side (drives operands and op select, observes results).
// slave : the ALU itself.
interface alu_i_if;
  logic [31:0] Num1;
  logic [31:0] Num2;
  logic [4:0]  OpSel;
  logic [31:0] Result;
  logic        Zero;
  logic [31:0] Result_q;
  logic        Zero_q;

  modport master (
    output Num1,
    output Num2,
    output OpSel,
    input  Result,
    input  Zero,
    input  Result_q,
    input  Zero_q
  );

  modport slave (
    input  Num1,
    input  Num2,
    input  OpSel,
    output Result,
    output Zero,
    output Result_q,
    output Zero_q
  );
endinterface

// File: rtl/alu_i.sv
// Integer ALU for the out-of-order core's integer execution unit.
// Computes RV32I OP/OP-IMM results combinationally so the ALU control unit
// can capture them in the issue cycle, and also keeps a one-cycle
// registered copy of the result and zero flag for pipelined consumers.
// OpSel: [2:0]=funct3, [3]=alt (funct7[5]), [4]=pass Num2 through.
module alu_i #(
  parameter int XLEN = 32
) (
  input  logic    clk,
  input  logic    rstn,
  alu_i_if.slave  bus
);

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  logic [XLEN-1:0] num1_s;
  logic [XLEN-1:0] num2_s;
  logic [2:0]      funct3_s;
  logic            alt_s;
  logic            pass_b_s;
  logic [4:0]      shamt_s;
  logic [XLEN-1:0] result_s;
  logic            zero_s;
  logic [XLEN-1:0] result_q_r;
  logic            zero_q_r;

  // Zero detect kept as a helper so the flag and its registered copy share one definition.
  function automatic logic is_zero(input logic [XLEN-1:0] value);
    return (value == {XLEN{1'b0}});
  endfunction

  assign num1_s   = bus.Num1;
  assign num2_s   = bus.Num2;
  assign funct3_s = bus.OpSel[2:0];
  assign alt_s    = bus.OpSel[3];
  assign pass_b_s = bus.OpSel[4];
  // Only the low five bits of operand B form the shift amount.
  assign shamt_s  = bus.Num2[4:0];

  // Result select: pass-through wins, otherwise decode funct3 (alt only matters for ADD/SRL).
  always_comb begin
    result_s = {XLEN{1'b0}};
    if (pass_b_s) begin
      result_s = num2_s;
    end else begin
      case (funct3_s)
        F3_ADD: begin
          if (alt_s) begin
            result_s = num1_s - num2_s;
          end else begin
            result_s = num1_s + num2_s;
          end
        end
        F3_SLL:  result_s = num1_s << shamt_s;
        F3_SLT:  result_s = {{(XLEN-1){1'b0}}, ($signed(num1_s) < $signed(num2_s))};
        F3_SLTU: result_s = {{(XLEN-1){1'b0}}, (num1_s < num2_s)};
        F3_XOR:  result_s = num1_s ^ num2_s;
        F3_SRL: begin
          if (alt_s) begin
            result_s = $unsigned($signed(num1_s) >>> shamt_s);
          end else begin
            result_s = num1_s >> shamt_s;
          end
        end
        F3_OR:   result_s = num1_s | num2_s;
        F3_AND:  result_s = num1_s & num2_s;
        default: result_s = {XLEN{1'b0}};
      endcase
    end
  end

  assign zero_s = is_zero(result_s);

  // Pipelined copy: loads every edge with no enable; async reset clears it immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      result_q_r <= {XLEN{1'b0}};
      zero_q_r   <= 1'b0;
    end else begin
      result_q_r <= result_s;
      zero_q_r   <= zero_s;
    end
  end

  assign bus.Result   = result_s;
  assign bus.Zero     = zero_s;
  assign bus.Result_q = result_q_r;
  assign bus.Zero_q   = zero_q_r;

endmodule

// File: tb/tb_alu_i.sv
// Directed bench for alu_i: hand-computed vectors for every op, the
// alt/pass-B decode rules, shift-amount masking, the registered copy and
// asynchronous reset behaviour.
module tb_alu_i;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  alu_i_if bus ();

  alu_i #(.XLEN(32)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a vector half a cycle away from the active edge.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    @(negedge clk);
    bus.Num1  = a;
    bus.Num2  = b;
    bus.OpSel = op;
    #1;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rstn      = 1'b0;
    bus.Num1  = 32'h0000_0003;
    bus.Num2  = 32'h0000_0005;
    bus.OpSel = 5'b01000;

    // Reset state, combinational path live during reset
    #3;
    check("rst_result_q", bus.Result_q, 32'h0000_0000);
    check("rst_zero_q", {31'b0, bus.Zero_q}, 32'h0000_0000);
    check("rst_comb_sub", bus.Result, 32'hFFFF_FFFE);
    @(posedge clk);
    #1;
    check("rst_hold_q", bus.Result_q, 32'h0000_0000);
    @(negedge clk);
    rstn = 1'b1;

    // SUB and its registered copy
    drive(32'h0000_0003, 32'h0000_0005, 5'b01000);
    check("sub", bus.Result, 32'hFFFF_FFFE);
    check("sub_zero", {31'b0, bus.Zero}, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("sub_q", bus.Result_q, 32'hFFFF_FFFE);
    check("sub_zero_q", {31'b0, bus.Zero_q}, 32'h0000_0000);

    // ADD wrap to zero
    drive(32'hFFFF_FFFF, 32'h0000_0001, 5'b00000);
    check("add_wrap", bus.Result, 32'h0000_0000);
    check("add_wrap_zero", {31'b0, bus.Zero}, 32'h0000_0001);
    @(posedge clk);
    #1;
    check("add_wrap_zero_q", {31'b0, bus.Zero_q}, 32'h0000_0001);
    check("add_wrap_q", bus.Result_q, 32'h0000_0000);

    // Plain ADD
    drive(32'h1234_5678, 32'h1111_1111, 5'b00000);
    check("add", bus.Result, 32'h2345_6789);

    // Shifts: Num2=0x24 so the amount is 4
    drive(32'h8000_0000, 32'h0000_0024, 5'b00101);
    check("srl", bus.Result, 32'h0800_0000);
    drive(32'h8000_0000, 32'h0000_0024, 5'b01101);
    check("sra", bus.Result, 32'hF800_0000);
    drive(32'h8000_0000, 32'h0000_0024, 5'b00001);
    check("sll", bus.Result, 32'h0000_0000);
    drive(32'h0000_0001, 32'hFFFF_FFE3, 5'b00001);
    check("sll_upper_ignored", bus.Result, 32'h0000_0008);
    drive(32'hA5A5_0001, 32'hFFFF_FFE0, 5'b01101);
    check("sra_by_zero", bus.Result, 32'hA5A5_0001);
    drive(32'h7FFF_FFFF, 32'h0000_001F, 5'b01101);
    check("sra_pos_31", bus.Result, 32'h0000_0000);
    drive(32'h8000_0000, 32'h0000_001F, 5'b01101);
    check("sra_neg_31", bus.Result, 32'hFFFF_FFFF);
    drive(32'h8000_0000, 32'h0000_0024, 5'b01001);
    check("sll_alt_ignored", bus.Result, 32'h0000_0000);

    // Compares
    drive(32'hFFFF_FFFF, 32'h0000_0001, 5'b00010);
    check("slt", bus.Result, 32'h0000_0001);
    drive(32'hFFFF_FFFF, 32'h0000_0001, 5'b00011);
    check("sltu", bus.Result, 32'h0000_0000);
    drive(32'h0000_0001, 32'hFFFF_FFFF, 5'b00010);
    check("slt_swap", bus.Result, 32'h0000_0000);
    drive(32'h0000_0001, 32'hFFFF_FFFF, 5'b00011);
    check("sltu_swap", bus.Result, 32'h0000_0001);
    drive(32'h0000_0001, 32'hFFFF_FFFF, 5'b01011);
    check("sltu_alt_ignored", bus.Result, 32'h0000_0001);
    drive(32'h0000_0005, 32'h0000_0005, 5'b00010);
    check("slt_equal", bus.Result, 32'h0000_0000);

    // Logic ops and pass-through
    drive(32'hF0F0_F0F0, 32'hFF00_FF00, 5'b00100);
    check("xor", bus.Result, 32'h0FF0_0FF0);
    drive(32'hF0F0_F0F0, 32'hFF00_FF00, 5'b01100);
    check("xor_alt_ignored", bus.Result, 32'h0FF0_0FF0);
    drive(32'hF0F0_F0F0, 32'hFF00_FF00, 5'b00110);
    check("or", bus.Result, 32'hFFF0_FFF0);
    drive(32'hF0F0_F0F0, 32'hFF00_FF00, 5'b00111);
    check("and", bus.Result, 32'hF000_F000);
    drive(32'hF0F0_F0F0, 32'hFF00_FF00, 5'b01111);
    check("and_alt_ignored", bus.Result, 32'hF000_F000);
    drive(32'hF0F0_F0F0, 32'hFF00_FF00, 5'b10000);
    check("pass_b", bus.Result, 32'hFF00_FF00);
    drive(32'hF0F0_F0F0, 32'hFF00_FF00, 5'b11101);
    check("pass_b_sra_bits", bus.Result, 32'hFF00_FF00);
    drive(32'hF0F0_F0F0, 32'h0000_0000, 5'b10111);
    check("pass_b_zero", {31'b0, bus.Zero}, 32'h0000_0001);

    // Reset mid-operation with Result_q holding 0x1234
    drive(32'h0000_1234, 32'h0000_0000, 5'b00000);
    @(posedge clk);
    #1;
    check("pre_reset_q", bus.Result_q, 32'h0000_1234);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_q", bus.Result_q, 32'h0000_0000);
    check("async_rst_zero_q", {31'b0, bus.Zero_q}, 32'h0000_0000);
    check("rst_comb_hold", bus.Result, 32'h0000_1234);
    bus.Num2 = 32'h0000_0001;
    #1;
    check("rst_comb_track", bus.Result, 32'h0000_1235);
    @(posedge clk);
    #1;
    check("rst_no_load", bus.Result_q, 32'h0000_0000);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("release_no_load", bus.Result_q, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("release_load", bus.Result_q, 32'h0000_1235);

    // Async reset clears a set Zero_q
    drive(32'h0000_0000, 32'h0000_0000, 5'b00110);
    @(posedge clk);
    #1;
    check("zero_q_set", {31'b0, bus.Zero_q}, 32'h0000_0001);
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_zero_q2", {31'b0, bus.Zero_q}, 32'h0000_0000);
    check("rst_comb_zero", {31'b0, bus.Zero}, 32'h0000_0001);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("zero_q_reload", {31'b0, bus.Zero_q}, 32'h0000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
